fetch_sequencer: RTL and testbench

Multi-cycle sequencer for the basic processor: owns the program counter, fetches 9-bit instructions from the instruction ROM, holds them stable for the combinational control decoder, and gates register-file and data-memory side effects. Sequences each instruction through FETCH → EXEC (→ MEM) so a data-memory access stalls the PC until the memory acknowledges. Sits between top level, instruction ROM, control decoder, register file and data memory.

---
 rtl/fetch_sequencer_pkg.sv | 23 ++
 rtl/fetch_sequencer.sv | 134 +++++++++++++
 tb/tb_fetch_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and defaults for the fetch/execute sequencer.
package fetch_sequencer_pkg;

  localparam int unsigned PC_W_DEF = 10;
  localparam int unsigned INSTR_W  = 9;
  localparam int unsigned CYC_W    = 16;

  localparam logic [INSTR_W-1:0] HALT_OP_DEF = 9'h1FF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  // True for the states in which a program is actively running.
  function automatic logic is_busy(input state_t s);
    return (s == S_FETCH) || (s == S_EXEC) || (s == S_MEM);
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM sequencer: owns the PC, holds the instruction
// for the decoder and gates register-file writes to the commit cycle.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned         PC_W        = PC_W_DEF,
  parameter logic [PC_W-1:0]     START_ADDR  = '0,
  parameter int unsigned         MEM_TIMEOUT = 15,
  parameter logic [INSTR_W-1:0]  HALT_OP     = HALT_OP_DEF
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  output logic [PC_W-1:0]     InstrAddr,
  input  logic [INSTR_W-1:0]  InstrIn,
  output logic [INSTR_W-1:0]  InstrOut,
  input  logic                JumpEn,
  input  logic [PC_W-1:0]     Target,
  input  logic                ReadMem,
  input  logic                WriteMem,
  input  logic                WriteEnIn,
  output logic                WriteEnOut,
  output logic                MemReq,
  input  logic                MemAck,
  output logic                Busy,
  output logic                Done,
  output logic                Error,
  output logic [CYC_W-1:0]    CycleCount
);

  localparam int unsigned      TO_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [TO_W-1:0]      to_q, to_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic                 busy_q;
  logic                 mem_req_q;
  logic                 we_c;

  // Next-state, datapath updates and the commit-cycle write enable.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    to_d    = to_q;
    done_d  = done_q;
    error_d = error_q;
    we_c    = 1'b0;
    cyc_d   = (busy_q && (cyc_q != '1)) ? cyc_q + CYC_W'(1) : cyc_q;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (Start) begin
          state_d = S_FETCH;
          pc_d    = START_ADDR;
          cyc_d   = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      S_FETCH: begin
        instr_d = InstrIn;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (instr_q == HALT_OP) begin
          state_d = S_HALT;
          done_d  = 1'b1;
        end else if (ReadMem || WriteMem) begin
          state_d = S_MEM;
          to_d    = '0;
        end else begin
          we_c    = WriteEnIn;
          pc_d    = JumpEn ? Target : pc_q + PC_W'(1);
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        // An acknowledge in the expiry cycle still commits.
        if (MemAck) begin
          we_c    = WriteEnIn;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_FETCH;
        end else if (to_q == TO_LAST) begin
          state_d = S_HALT;
          error_d = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; Busy/MemReq registered from next state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      pc_q      <= START_ADDR;
      instr_q   <= '0;
      to_q      <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      cyc_q     <= '0;
      busy_q    <= 1'b0;
      mem_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      to_q      <= to_d;
      done_q    <= done_d;
      error_q   <= error_d;
      cyc_q     <= cyc_d;
      busy_q    <= is_busy(state_d);
      mem_req_q <= (state_d == S_MEM);
    end
  end

  assign InstrAddr  = pc_q;
  assign InstrOut   = instr_q;
  assign WriteEnOut = we_c;
  assign MemReq     = mem_req_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Error      = error_q;
  assign CycleCount = cyc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: ROM and decoder models, commit scoreboard.
module tb_fetch_sequencer;

  localparam logic [8:0] HALT  = 9'h1FF;
  localparam logic [8:0] ALU_W = 9'h000;  // ALU op with register write
  localparam logic [8:0] ALU_N = 9'h040;  // ALU op without register write
  localparam logic [8:0] LOAD  = 9'h080;  // memory read with writeback
  localparam logic [8:0] STORE = 9'h0C0;  // memory write
  localparam logic [8:0] JMP   = 9'h100;  // jump, 6-bit sign-extended target

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [9:0]  InstrAddr;
  logic [8:0]  InstrIn;
  logic [8:0]  InstrOut;
  logic        JumpEn;
  logic [9:0]  Target;
  logic        ReadMem;
  logic        WriteMem;
  logic        WriteEnIn;
  logic        WriteEnOut;
  logic        MemReq;
  logic        MemAck;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic [15:0] CycleCount;

  logic [8:0]  rom [1024];
  logic        jump_ovr;
  logic [2:0]  op;
  logic [9:0]  sb [$];
  int          checks = 0;
  int          errors = 0;
  int          we_cnt = 0;
  int          cyc;
  int          we_before;

  fetch_sequencer #(
    .PC_W(10), .START_ADDR(10'h000), .MEM_TIMEOUT(15), .HALT_OP(9'h1FF)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .InstrAddr(InstrAddr),
    .InstrIn(InstrIn), .InstrOut(InstrOut), .JumpEn(JumpEn), .Target(Target),
    .ReadMem(ReadMem), .WriteMem(WriteMem), .WriteEnIn(WriteEnIn),
    .WriteEnOut(WriteEnOut), .MemReq(MemReq), .MemAck(MemAck), .Busy(Busy),
    .Done(Done), .Error(Error), .CycleCount(CycleCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign InstrIn = rom[InstrAddr];
  assign op      = InstrOut[8:6];

  // Control decoder model driven by the held instruction.
  always_comb begin
    ReadMem   = 1'b0;
    WriteMem  = 1'b0;
    WriteEnIn = 1'b0;
    JumpEn    = jump_ovr;
    Target    = jump_ovr ? 10'h3FF : {{4{InstrOut[5]}}, InstrOut[5:0]};
    if (InstrOut != HALT) begin
      case (op)
        3'd0: WriteEnIn = 1'b1;
        3'd2: begin ReadMem = 1'b1; WriteEnIn = 1'b1; end
        3'd3: WriteMem = 1'b1;
        3'd4: JumpEn = 1'b1;
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Commit monitor: each write-enable pulse pops the expected commit PC.
  always @(negedge Clk) begin
    if (Reset === 1'b1 && WriteEnOut === 1'b1) begin
      we_cnt++;
      if (sb.size() == 0) chk("we_unexpected_sb_size", 32'(sb.size()), 32'd1);
      else chk("we_commit_pc", 32'(InstrAddr), 32'(sb.pop_front()));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = HALT;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // Runs from the first FETCH until Done/Error; MemAck after ack_dly MEM cycles (-1: never).
  task automatic run(input int ack_dly, output int ncyc);
    int mcnt;
    mcnt = 0;
    ncyc = 0;
    while (!(Done || Error) && ncyc < 200) begin
      if (MemReq) begin
        MemAck = (mcnt == ack_dly);
        mcnt++;
      end else begin
        MemAck = 1'b0;
        mcnt   = 0;
      end
      tick();
      ncyc++;
    end
    MemAck = 1'b0;
    if (ncyc >= 200) chk("run_bound", {31'b0, Done | Error}, 32'd1);
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; MemAck = 1'b0; jump_ovr = 1'b0;
    clear_rom();
    #2;
    chk("rst_addr", 32'(InstrAddr), 32'h0);
    chk("rst_instr", 32'(InstrOut), 32'h0);
    chk("rst_memreq", 32'(MemReq), 32'h0);
    chk("rst_we", 32'(WriteEnOut), 32'h0);
    chk("rst_busy", 32'(Busy), 32'h0);
    chk("rst_done_err", 32'({Done, Error}), 32'h0);
    chk("rst_cycles", 32'(CycleCount), 32'h0);
    tick(); tick();
    Reset = 1'b1;
    tick();
    chk("idle_busy", 32'(Busy), 32'h0);

    // Three ALU ops then HALT.
    rom[0] = ALU_W; rom[1] = ALU_W; rom[2] = ALU_W; rom[3] = HALT;
    sb.push_back(10'h000); sb.push_back(10'h001); sb.push_back(10'h002);
    we_before = we_cnt;
    pulse_start();
    chk("a_first_addr", 32'(InstrAddr), 32'h0);
    run(-1, cyc);
    chk("a_cycles", 32'(cyc), 32'd8);
    chk("a_cyclecount", 32'(CycleCount), 32'd8);
    chk("a_done_err", 32'({Done, Error}), 32'b10);
    chk("a_busy", 32'(Busy), 32'h0);
    chk("a_halt_pc", 32'(InstrAddr), 32'h3);
    chk("a_instr", 32'(InstrOut), 32'h1FF);
    chk("a_we_pulses", 32'(we_cnt - we_before), 32'd3);
    chk("a_sb_empty", 32'(sb.size()), 32'd0);

    // Load at PC=2 acked two cycles after MemReq.
    clear_rom();
    rom[0] = ALU_W; rom[1] = ALU_W; rom[2] = LOAD; rom[3] = HALT;
    sb.push_back(10'h000); sb.push_back(10'h001); sb.push_back(10'h002);
    pulse_start();
    chk("b_done_cleared", 32'(Done), 32'h0);
    run(2, cyc);
    chk("b_cycles", 32'(cyc), 32'd11);
    chk("b_cyclecount", 32'(CycleCount), 32'd11);
    chk("b_halt_pc", 32'(InstrAddr), 32'h3);
    chk("b_sb_empty", 32'(sb.size()), 32'd0);

    // Taken jump from PC=1 to 5.
    clear_rom();
    rom[0] = ALU_W; rom[1] = JMP | 9'h005; rom[5] = ALU_W; rom[6] = HALT;
    sb.push_back(10'h000); sb.push_back(10'h005);
    we_before = we_cnt;
    pulse_start();
    run(-1, cyc);
    chk("j_cycles", 32'(cyc), 32'd8);
    chk("j_halt_pc", 32'(InstrAddr), 32'h6);
    chk("j_we_pulses", 32'(we_cnt - we_before), 32'd2);
    chk("j_sb_empty", 32'(sb.size()), 32'd0);

    // JumpEn held high during a load: MEM must ignore it.
    clear_rom();
    rom[0] = LOAD; rom[1] = HALT;
    sb.push_back(10'h000);
    jump_ovr = 1'b1;
    pulse_start();
    run(1, cyc);
    jump_ovr = 1'b0;
    chk("jm_cycles", 32'(cyc), 32'd6);
    chk("jm_halt_pc", 32'(InstrAddr), 32'h1);
    chk("jm_sb_empty", 32'(sb.size()), 32'd0);

    // Store never acknowledged: timeout halts with Error.
    clear_rom();
    rom[0] = STORE; rom[1] = HALT;
    we_before = we_cnt;
    pulse_start();
    run(-1, cyc);
    chk("to_cycles", 32'(cyc), 32'd17);
    chk("to_done_err", 32'({Done, Error}), 32'b01);
    chk("to_pc", 32'(InstrAddr), 32'h0);
    chk("to_we_pulses", 32'(we_cnt - we_before), 32'd0);
    chk("to_memreq", 32'(MemReq), 32'h0);
    for (int i = 0; i < 5; i++) tick();
    chk("to_held_err", 32'({Done, Error, Busy}), 32'b010);
    pulse_start();
    chk("to_restart_err", 32'({Done, Error, Busy}), 32'b001);
    chk("to_restart_cycles", 32'(CycleCount), 32'h0);
    chk("to_restart_addr", 32'(InstrAddr), 32'h0);
    run(0, cyc);
    chk("to_rerun_cycles", 32'(cyc), 32'd5);
    chk("to_rerun_done_err", 32'({Done, Error}), 32'b10);

    // Wrap from 10'h3FF to 0, with Start ignored while busy.
    clear_rom();
    rom[0] = JMP | 9'h03F; rom[10'h3FF] = ALU_W;
    sb.push_back(10'h3FF);
    pulse_start();
    tick();
    tick();
    chk("w_jump_addr", 32'(InstrAddr), 32'h3FF);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("w_start_busy_addr", 32'(InstrAddr), 32'h3FF);
    chk("w_start_busy_cycles", 32'(CycleCount), 32'd3);
    tick();
    chk("w_wrap_addr", 32'(InstrAddr), 32'h0);
    chk("w_sb_empty", 32'(sb.size()), 32'd0);

    // Asynchronous reset while a load waits in MEM.
    rom[0] = ALU_N; rom[1] = LOAD;
    we_before = we_cnt;
    tick(); tick(); tick(); tick();
    chk("r_memreq_before", 32'(MemReq), 32'h1);
    chk("r_addr_before", 32'(InstrAddr), 32'h1);
    MemAck = 1'b1;
    #1 Reset = 1'b0;
    #1;
    chk("r_addr", 32'(InstrAddr), 32'h0);
    chk("r_memreq", 32'(MemReq), 32'h0);
    chk("r_we", 32'(WriteEnOut), 32'h0);
    chk("r_busy", 32'(Busy), 32'h0);
    chk("r_cycles", 32'(CycleCount), 32'h0);
    chk("r_instr", 32'(InstrOut), 32'h0);
    MemAck = 1'b0;
    tick();
    Reset = 1'b1;
    tick(); tick();
    chk("r_idle_after", 32'({Busy, Done, Error}), 32'b000);
    chk("r_no_commit", 32'(we_cnt - we_before), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
